adder_bist: RTL and testbench

- Built-in self-test controller for the team's 32-bit adders (carry-bypass and siblings) with the a/b/Cin -> sum/Cout/of interface.
- Acts as the stimulus-and-check end of that interface: drives operands, waits for the adder under test, and compares its results against an internal golden model.
- Accumulates error statistics and reports pass or fail.
- Sits beside the adder under test in synthesised test wrappers, so adder checks run on silicon or FPGA without a simulator bench.

---
 rtl/adder_bist.sv | 146 ++++++++++++++
 tb/tb_adder_bist.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist.sv
// Built-in self-test controller for a/b/cin -> sum/cout/of adders: drives LFSR operands,
// checks the adder under test against a golden sum and reports statistics. Optional macro: BIST_CORNER_EN.
module adder_bist #(
  parameter int          WIDTH       = 32,
  parameter int          NUM_VECTORS = 256,
  parameter int          DUT_LAT     = 1,
  parameter logic [31:0] SEED        = 32'hACE1_2468,
  parameter int          ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  input  logic             dut_of,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_fail_idx,
  output logic [15:0]      vec_idx
);

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam int          WC_W = $clog2(DUT_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t            state;
  logic [31:0]       lfsr;
  logic [WC_W-1:0]   wait_cnt;
  logic [WIDTH-1:0]  exp_sum;
  logic              exp_cout;
  logic              exp_of;

  logic [31:0]       step1;
  logic [31:0]       step2;
  logic [WIDTH-1:0]  nxt_a;
  logic [WIDTH-1:0]  nxt_b;
  logic              nxt_cin;
  logic              use_lfsr;
  logic [WIDTH:0]    sum_full;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Next vector and its golden result, computed while in DRIVE.
  always_comb begin
    step1    = lfsr_step(lfsr);
    step2    = lfsr_step(step1);
    nxt_a    = step1[WIDTH-1:0];
    nxt_cin  = step1[31];
    nxt_b    = step2[WIDTH-1:0];
    use_lfsr = 1'b1;
`ifdef BIST_CORNER_EN
    if (vec_idx < 16'd4) begin
      use_lfsr = 1'b0;
      case (vec_idx[1:0])
        2'd0:    begin nxt_a = '0; nxt_b = '0; nxt_cin = 1'b1; end
        2'd1:    begin nxt_a = {1'b0, {(WIDTH-1){1'b1}}}; nxt_b = WIDTH'(1); nxt_cin = 1'b0; end
        2'd2:    begin nxt_a = {1'b1, {(WIDTH-1){1'b0}}}; nxt_b = {1'b1, {(WIDTH-1){1'b0}}}; nxt_cin = 1'b0; end
        default: begin nxt_a = '1; nxt_b = '1; nxt_cin = 1'b1; end
      endcase
    end
`endif
    sum_full = {1'b0, nxt_a} + {1'b0, nxt_b} + {{WIDTH{1'b0}}, nxt_cin};
  end

  always_comb begin
    mismatch = (dut_sum != exp_sum) || (dut_cout != exp_cout) || (dut_of != exp_of);
    err_next = err_count;
    if (mismatch && (err_count != {ERR_W{1'b1}})) err_next = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      lfsr           <= SEED;
      wait_cnt       <= '0;
      dut_a          <= '0;
      dut_b          <= '0;
      dut_cin        <= 1'b0;
      exp_sum        <= '0;
      exp_cout       <= 1'b0;
      exp_of         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= 16'hFFFF;
      vec_idx        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_DRIVE;
            lfsr           <= SEED;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= 16'hFFFF;
            vec_idx        <= '0;
          end
        end
        S_DRIVE: begin
          dut_a    <= nxt_a;
          dut_b    <= nxt_b;
          dut_cin  <= nxt_cin;
          exp_sum  <= sum_full[WIDTH-1:0];
          exp_cout <= sum_full[WIDTH];
          exp_of   <= (nxt_a[WIDTH-1] == nxt_b[WIDTH-1]) && (sum_full[WIDTH-1] != nxt_a[WIDTH-1]);
          if (use_lfsr) lfsr <= step2;
          wait_cnt <= '0;
          state    <= (DUT_LAT == 1) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WC_W'(DUT_LAT - 2)) state <= S_CHECK;
          else wait_cnt <= wait_cnt + WC_W'(1);
        end
        S_CHECK: begin
          err_count <= err_next;
          if (mismatch && (first_fail_idx == 16'hFFFF)) first_fail_idx <= vec_idx;
          // pass must see this last vector's verdict, hence err_next rather than err_count.
          if (vec_idx == 16'(NUM_VECTORS - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            vec_idx <= vec_idx + 16'd1;
            state   <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: two instances (32-bit combinational adder, 16-bit adder registered two deep)
// checked against a spec-level vector/arithmetic model with an expected-operand queue.
module tb_adder_bist;

  localparam int          QW   = 65;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  // clock/reset block
  always #5 clk = ~clk;

  // instance A: WIDTH 32, 16 vectors, DUT_LAT 1
  logic [31:0] a_dut_a, a_dut_b, a_sum;
  logic        a_cin, a_cout, a_of, a_busy, a_done, a_pass;
  logic [15:0] a_err, a_ff, a_vec;
  // instance B: WIDTH 16, 8 vectors, DUT_LAT 3, ERR_W 2
  logic [15:0] b_dut_a, b_dut_b, b_sum;
  logic        b_cin, b_cout, b_of, b_busy, b_done, b_pass;
  logic [1:0]  b_err;
  logic [15:0] b_ff, b_vec;

  adder_bist #(.WIDTH(32), .NUM_VECTORS(16), .DUT_LAT(1), .SEED(SEED), .ERR_W(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a),
    .dut_a(a_dut_a), .dut_b(a_dut_b), .dut_cin(a_cin),
    .dut_sum(a_sum), .dut_cout(a_cout), .dut_of(a_of),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .first_fail_idx(a_ff), .vec_idx(a_vec)
  );

  adder_bist #(.WIDTH(16), .NUM_VECTORS(8), .DUT_LAT(3), .SEED(SEED), .ERR_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b),
    .dut_a(b_dut_a), .dut_b(b_dut_b), .dut_cin(b_cin),
    .dut_sum(b_sum), .dut_cout(b_cout), .dut_of(b_of),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .first_fail_idx(b_ff), .vec_idx(b_vec)
  );

  // Reference arithmetic: returns {of, cout, sum} using integer math on w-bit operands.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input int w);
    longint mask, half, ua, ub, sa, sb, full, sg;
    logic   of, co;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    full = ua + ub + longint'(cin);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    sg   = sa + sb + longint'(cin);
    of   = (sg >= half) || (sg < -half);
    co   = ((full >> w) & 1) != 0;
    return {of, co, 32'(full & mask)};
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Adders under test, with selectable faults.
  int mode_a = 0;
  int mode_b = 0;
  logic [33:0] ra_now, ra_p1, ra_p2, ra_out, rb_now, rb_p1, rb_p2, rb_out;

  always_comb ra_now = ref_add(a_dut_a, a_dut_b, a_cin, 32);
  always_comb rb_now = ref_add({16'h0, b_dut_a}, {16'h0, b_dut_b}, b_cin, 16);

  always @(posedge clk) begin
    ra_p1 <= ra_now;
    ra_p2 <= ra_p1;
    rb_p1 <= rb_now;
    rb_p2 <= rb_p1;
  end

  always_comb begin
    ra_out = (mode_a == 3) ? ra_p2 : ra_now;
    if (mode_a == 1) ra_out[0] = 1'b0;
    if (mode_a == 2) ra_out[33] = ~ra_out[33];
    rb_out = rb_p2;
    if (mode_b == 1) rb_out[33] = ~rb_out[33];
  end

  assign a_sum  = ra_out[31:0];
  assign a_cout = ra_out[32];
  assign a_of   = ra_out[33];
  assign b_sum  = rb_out[15:0];
  assign b_cout = rb_out[32];
  assign b_of   = rb_out[33];

  // Observation mux so one run task serves both instances.
  int sel = 0;
  logic [31:0] m_a, m_b;
  logic        m_cin, m_busy, m_done, m_pass;
  logic [15:0] m_err, m_ff, m_vec;

  always_comb begin
    m_a = a_dut_a; m_b = a_dut_b; m_cin = a_cin; m_busy = a_busy; m_done = a_done;
    m_pass = a_pass; m_err = a_err; m_ff = a_ff; m_vec = a_vec;
    if (sel == 1) begin
      m_a = {16'h0, b_dut_a}; m_b = {16'h0, b_dut_b}; m_cin = b_cin; m_busy = b_busy;
      m_done = b_done; m_pass = b_pass; m_err = {14'h0, b_err}; m_ff = b_ff; m_vec = b_vec;
    end
  end

  // scoreboard
  logic [QW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds the expected vector list and predicts error statistics for one run.
  task automatic model_run(input int w, input int n, input int errmax, input int fault,
                           output int exp_err, output int exp_ff);
    logic [31:0] s, mask, va, vb;
    logic        vc;
    logic [33:0] r;
    bit          mism;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    s = SEED;
    exp_err = 0;
    exp_ff  = 16'hFFFF;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
`ifdef BIST_CORNER_EN
      if (k < 4) begin
        case (k)
          0:       begin va = 0;          vb = 0;               vc = 1'b1; end
          1:       begin va = mask >> 1;  vb = 1;               vc = 1'b0; end
          2:       begin va = (mask >> 1) + 1; vb = (mask >> 1) + 1; vc = 1'b0; end
          default: begin va = mask;       vb = mask;            vc = 1'b1; end
        endcase
      end else begin
`endif
        s  = lfsr_next(s);
        va = s & mask;
        vc = s[31];
        s  = lfsr_next(s);
        vb = s & mask;
`ifdef BIST_CORNER_EN
      end
`endif
      exp_q.push_back({vc, vb, va});
      r    = ref_add(va, vb, vc, w);
      mism = (fault == 1) ? r[0] : (fault == 2);
      if (mism) begin
        if (exp_err < errmax) exp_err++;
        if (exp_ff == 16'hFFFF) exp_ff = k;
      end
    end
  endtask

  // One BIST run on instance sel; optional start poke during busy or mid-run reset at a vector.
  task automatic run(input int s_sel, input int fault, input int poke_k, input int rst_k,
                     input bit predict);
    int n, lat, w, errmax, exp_err, exp_ff;
    logic [QW-1:0] v;
    sel    = s_sel;
    n      = (s_sel == 0) ? 16 : 8;
    lat    = (s_sel == 0) ? 1 : 3;
    w      = (s_sel == 0) ? 32 : 16;
    errmax = (s_sel == 0) ? 65535 : 3;
    mode_a = (s_sel == 0) ? fault : 0;
    mode_b = (s_sel == 1 && fault == 2) ? 1 : 0;
    model_run(w, n, errmax, fault, exp_err, exp_ff);
    @(negedge clk);
    if (s_sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk("busy_after_start", m_busy, 1);
    chk("done_cleared", m_done, 0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      v = exp_q.pop_front();
      chk($sformatf("a[%0d]", k), m_a, v[31:0]);
      chk($sformatf("b[%0d]", k), m_b, v[63:32]);
      chk($sformatf("cin[%0d]", k), m_cin, v[64]);
      chk($sformatf("vec_idx[%0d]", k), m_vec, k);
      chk($sformatf("busy[%0d]", k), m_busy, 1);
      if (k == rst_k) begin
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_dut_a", m_a, 0);
        chk("rst_vec_idx", m_vec, 0);
        chk("rst_err", m_err, 0);
        chk("rst_ff", m_ff, 16'hFFFF);
        return;
      end
      if (k == poke_k) begin
        if (s_sel == 0) start_a = 1'b1; else start_b = 1'b1;
      end
      for (int i = 0; i < lat; i++) begin
        if (!(k == n - 1 && i == 0)) chk($sformatf("done_early[%0d]", k), m_done, 0);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
      end
    end
    chk("done_on_time", m_done, 1);
    chk("busy_end", m_busy, 0);
    if (predict) begin
      chk("pass", m_pass, (exp_err == 0));
      chk("err_count", m_err, exp_err);
      chk("first_fail_idx", m_ff, exp_ff);
    end else begin
      chk("pass_expect_fail", m_pass, 0);
    end
    // done and results hold in DONE
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", m_done, 1);
    chk("a_hold", m_a, v[31:0]);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_a", a_busy, 0);
    chk("reset_done_a", a_done, 0);
    chk("reset_pass_a", a_pass, 0);
    chk("reset_err_a", a_err, 0);
    chk("reset_ff_a", a_ff, 16'hFFFF);
    chk("reset_vec_a", a_vec, 0);
    chk("reset_ops_a", {a_dut_a, a_dut_b, a_cin}, 0);
    chk("reset_busy_b", b_busy, 0);
    chk("reset_ff_b", b_ff, 16'hFFFF);
    chk("reset_ops_b", {b_dut_a, b_dut_b, b_cin}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run(0, 0, -1, -1, 1'b1);   // ideal adder
    run(0, 1, -1, -1, 1'b1);   // sum[0] stuck at 0, restart from DONE
    run(0, 2, -1, -1, 1'b1);   // overflow inverted
    run(0, 3, -1, -1, 1'b0);   // two-deep adder with too short a latency
    run(0, 0, -1, 5, 1'b0);    // reset mid-run at vector 5
    run(0, 0, 2, -1, 1'b1);    // fresh run from SEED, start poked while busy
    run(1, 0, -1, -1, 1'b1);   // 16-bit, two-deep adder, DUT_LAT 3
    run(1, 2, -1, -1, 1'b1);   // overflow inverted, 2-bit counter saturates
    run(1, 0, 4, -1, 1'b1);    // clean rerun after failures clears stats

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
